// File: rtl/umi_req_arbiter.sv
// N-to-1 UMI request arbiter: round-robin selection, grant held across a burst until EOM.
// Optional build macro UMI_REQ_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module umi_req_arbiter #(
   parameter int N  = 4,
   parameter int CW = 32,
   parameter int AW = 64,
   parameter int DW = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         in_valid,
   input  logic [N*CW-1:0]      in_cmd,
   input  logic [N*AW-1:0]      in_dstaddr,
   input  logic [N*AW-1:0]      in_srcaddr,
   input  logic [N*DW-1:0]      in_data,
   output logic [N-1:0]         in_ready,
   output logic                 out_valid,
   output logic [CW-1:0]        out_cmd,
   output logic [AW-1:0]        out_dstaddr,
   output logic [AW-1:0]        out_srcaddr,
   output logic [DW-1:0]        out_data,
   input  logic                 out_ready,
   output logic [$clog2(N)-1:0] grant_id
);

   localparam int IW = $clog2(N);
   localparam int EOM_BIT = 22;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t        fsm;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] owner;
   logic [IW-1:0] winner;
   logic [IW-1:0] sel;
   logic [IW:0]   scan_idx;
   logic [IW-1:0] scan_pos;
   logic          any_valid;
   logic          granted;
   logic          xfer;
   logic          eom;

   // Scan from the farthest candidate back to rr_ptr so the closest valid one is assigned last.
   always_comb begin
      winner   = rr_ptr;
      scan_idx = '0;
      scan_pos = '0;
      for (int k = 0; k < N; k++) begin
         scan_idx = {1'b0, rr_ptr} + (IW+1)'(N - 1 - k);
         if (scan_idx >= (IW+1)'(N))
            scan_idx = scan_idx - (IW+1)'(N);
         scan_pos = scan_idx[IW-1:0];
         if (in_valid[scan_pos])
            winner = scan_pos;
      end
   end

   assign any_valid = |in_valid;
   assign sel       = (fsm == LOCKED) ? owner : winner;
   assign granted   = (fsm == LOCKED) || any_valid;

   always_comb begin
      out_valid   = 1'b0;
      grant_id    = '0;
      in_ready    = '0;
      out_cmd     = '0;
      out_dstaddr = '0;
      out_srcaddr = '0;
      out_data    = '0;
      if (!reset) begin
         grant_id  = sel;
         out_valid = (fsm == LOCKED) ? in_valid[owner] : any_valid;
         if (granted) begin
            for (int i = 0; i < N; i++) begin
               if (sel == IW'(i)) begin
                  in_ready[i] = out_ready;
                  out_cmd     = in_cmd[i*CW +: CW];
                  out_dstaddr = in_dstaddr[i*AW +: AW];
                  out_srcaddr = in_srcaddr[i*AW +: AW];
                  out_data    = in_data[i*DW +: DW];
               end
            end
         end
      end
   end

   assign xfer = out_valid & out_ready;
   assign eom  = out_cmd[EOM_BIT];

   // A non-EOM beat locks the current selection until its burst finishes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm   <= IDLE;
         owner <= '0;
      end else if (xfer) begin
         if (eom) begin
            fsm <= IDLE;
         end else begin
            fsm   <= LOCKED;
            owner <= sel;
         end
      end
   end

`ifdef UMI_REQ_ARB_FIXED_PRIO_EN
   assign rr_ptr = '0;
`else
   logic [IW-1:0] next_ptr;

   assign next_ptr = (sel == IW'(N - 1)) ? '0 : sel + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rr_ptr <= '0;
      else if (xfer && eom)
         rr_ptr <= next_ptr;
   end
`endif

endmodule
